// File: rtl/fix_fifo_arb_pkg.sv
// Shared types and the round-robin pick helper for the FIX FIFO write arbiter
// and any other scheduler that needs rotate-priority selection.
package fix_fifo_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    localparam int MAX_REQ = 8;
    localparam int IDX_W   = $clog2(MAX_REQ);

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } rr_pick_t;

    // Scan from last+1 upward with wrap over the first n lanes; nearest set bit wins.
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                         input logic [IDX_W-1:0]   last,
                                         input int                 n);
        rr_pick_t r;
        int       p;
        r = '0;
        for (int k = MAX_REQ; k >= 1; k--) begin
            if (k <= n) begin
                p = (int'(last) + k) % n;
                if (req[p[IDX_W-1:0]]) begin
                    r.found = 1'b1;
                    r.idx   = p[IDX_W-1:0];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fix_fifo_wr_arbiter_rr_picker.sv
// Combinational rotate-priority encoder: returns the first requesting lane after
// the previous winner, wrapping around.
module fix_fifo_wr_arbiter_rr_picker
    import fix_fifo_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] last_i,
    output logic [$clog2(N)-1:0] idx_o,
    output logic                 found_o
);

    localparam int LW = $clog2(N);

    logic [MAX_REQ-1:0] w_req;
    logic [IDX_W-1:0]   w_last;
    rr_pick_t           w_pick;

    assign w_req   = MAX_REQ'(req_i);
    assign w_last  = IDX_W'(last_i);
    assign w_pick  = rr_pick(w_req, w_last, N);
    assign idx_o   = LW'(w_pick.idx);
    assign found_o = w_pick.found;

endmodule

// File: rtl/fix_fifo_wr_arbiter.sv
// Per-message round-robin arbiter sharing the message FIFO write port between
// FIX producer lanes, with FIFO backpressure and a dead-producer watchdog.
module fix_fifo_wr_arbiter
    import fix_fifo_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]            req_last_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic                          full_i,
    output logic                          wr_cs_o,
    output logic                          wr_en_o,
    output logic [DATA_WIDTH-1:0]         data_o,
    output logic [NUM_REQ-1:0]            grant_o,
    output logic                          busy_o,
    output logic                          timeout_o,
    output logic [$clog2(NUM_REQ)-1:0]    timeout_id_o
);

    localparam int LW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    state_t          r_state;
    logic [LW-1:0]   r_owner;
    logic [LW-1:0]   r_rr_last;
    logic [LW-1:0]   r_timeout_id;
    logic [CW-1:0]   r_idle_cnt;
    logic            r_timeout;

    logic [LW-1:0]         w_pick_idx;
    logic                  w_pick_found;
    logic                  w_xfer;
    logic                  w_owner_valid;
    logic                  w_owner_last;
    logic                  w_accept;
    logic                  w_stall_tick;
    logic                  w_abort;
    logic [NUM_REQ-1:0]    w_onehot;
    logic [DATA_WIDTH-1:0] w_lane_data;

    fix_fifo_wr_arbiter_rr_picker #(
        .N (NUM_REQ)
    ) u_picker (
        .req_i   (req_valid_i),
        .last_i  (r_rr_last),
        .idx_o   (w_pick_idx),
        .found_o (w_pick_found)
    );

    assign w_xfer        = (r_state == XFER);
    assign w_owner_valid = req_valid_i[r_owner];
    assign w_owner_last  = req_last_i[r_owner];
    assign w_accept      = w_xfer & w_owner_valid & ~full_i;
    assign w_onehot      = NUM_REQ'(1) << r_owner;

    // FIFO-full cycles are not owner idleness, so they never feed the watchdog.
    assign w_stall_tick  = w_xfer & ~w_owner_valid & ~full_i;
    assign w_abort       = w_stall_tick & (r_idle_cnt >= CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        w_lane_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_owner == LW'(i)) begin
                w_lane_data = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign wr_en_o      = w_accept;
    assign wr_cs_o      = w_accept;
    assign data_o       = w_xfer ? w_lane_data : '0;
    assign grant_o      = w_xfer ? w_onehot : '0;
    assign req_ready_o  = (w_xfer & ~full_i) ? w_onehot : '0;
    assign busy_o       = w_xfer;
    assign timeout_o    = r_timeout;
    assign timeout_id_o = r_timeout_id;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_owner      <= '0;
            r_rr_last    <= LW'(NUM_REQ - 1);
            r_idle_cnt   <= '0;
            r_timeout    <= 1'b0;
            r_timeout_id <= '0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_idle_cnt <= '0;
                    if (w_pick_found) begin
                        r_owner <= w_pick_idx;
                        r_state <= XFER;
                    end
                end
                XFER: begin
                    if (w_accept) begin
                        r_idle_cnt <= '0;
                        if (w_owner_last) begin
                            r_rr_last <= r_owner;
                            r_state   <= IDLE;
                        end
                    end else if (w_abort) begin
                        // Dead producer loses the port and its turn; any late tail is a new message.
                        r_timeout    <= 1'b1;
                        r_timeout_id <= r_owner;
                        r_rr_last    <= r_owner;
                        r_idle_cnt   <= '0;
                        r_state      <= IDLE;
                    end else if (w_stall_tick && (r_idle_cnt != '1)) begin
                        r_idle_cnt <= r_idle_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fix_fifo_wr_arbiter.sv
// Directed bench for fix_fifo_wr_arbiter: vector table for arbitration order,
// hand sequences for backpressure, watchdog abort and async reset.
module tb_fix_fifo_wr_arbiter;

    localparam int NR = 4;
    localparam int DW = 32;

    logic            clk;
    logic            rst;
    logic [NR-1:0]   reqValid;
    logic [NR*DW-1:0] reqData;
    logic [NR-1:0]   reqLast;
    logic [NR-1:0]   reqReady;
    logic            full;
    logic            wrCs;
    logic            wrEn;
    logic [DW-1:0]   dataOut;
    logic [NR-1:0]   grant;
    logic            busy;
    logic            timeoutPulse;
    logic [1:0]      timeoutId;

    int checks = 0;
    int errors = 0;

    fix_fifo_wr_arbiter #(
        .NUM_REQ        (NR),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (reqValid),
        .req_data_i   (reqData),
        .req_last_i   (reqLast),
        .req_ready_o  (reqReady),
        .full_i       (full),
        .wr_cs_o      (wrCs),
        .wr_en_o      (wrEn),
        .data_o       (dataOut),
        .grant_o      (grant),
        .busy_o       (busy),
        .timeout_o    (timeoutPulse),
        .timeout_id_o (timeoutId)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         rstBefore;
        logic [3:0]   valid;
        logic [3:0]   last;
        logic [127:0] data;
        logic [3:0]   expGrant;
        logic         expWr;
        logic [31:0]  expData;
        logic [3:0]   expReady;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] word(input int lane, input int n);
        logic [3:0] l4;
        logic [7:0] n8;
        l4 = 4'(lane);
        n8 = 8'(n);
        return {16'hF1C0, l4, 4'h0, n8};
    endfunction

    function automatic logic [127:0] pack4(input logic [31:0] w0, input logic [31:0] w1,
                                           input logic [31:0] w2, input logic [31:0] w3);
        return {w3, w2, w1, w0};
    endfunction

    task automatic addRow(input logic rb, input logic [3:0] v, input logic [3:0] l,
                          input logic [127:0] d, input logic [3:0] eg, input logic ew,
                          input logic [31:0] ed, input logic [3:0] er);
        vec_t r;
        r.rstBefore = rb;
        r.valid     = v;
        r.last      = l;
        r.data      = d;
        r.expGrant  = eg;
        r.expWr     = ew;
        r.expData   = ed;
        r.expReady  = er;
        vecs.push_back(r);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic nextCycle;
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs;
        reqValid = '0;
        reqLast  = '0;
        reqData  = '0;
        full     = 1'b0;
    endtask

    task automatic doReset;
        clearInputs();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        if (v.rstBefore) doReset();
        nextCycle();
        reqValid = v.valid;
        reqLast  = v.last;
        reqData  = v.data;
        full     = 1'b0;
        #3;
        checkOutput($sformatf("vec%0d grant", idx), 32'(grant), 32'(v.expGrant));
        checkOutput($sformatf("vec%0d wr_en", idx), 32'(wrEn), 32'(v.expWr));
        checkOutput($sformatf("vec%0d wr_cs", idx), 32'(wrCs), 32'(v.expWr));
        checkOutput($sformatf("vec%0d data", idx), dataOut, v.expData);
        checkOutput($sformatf("vec%0d ready", idx), 32'(reqReady), 32'(v.expReady));
    endtask

    initial begin
        logic [127:0] allData;
        int order[6];

        // Test 1: held in reset with every lane requesting.
        rst      = 1'b0;
        full     = 1'b0;
        reqValid = 4'b1111;
        reqLast  = 4'b1111;
        reqData  = pack4(word(0, 0), word(1, 0), word(2, 0), word(3, 0));
        repeat (3) begin
            @(posedge clk);
            #4;
            checkOutput("rst grant", 32'(grant), 32'h0);
            checkOutput("rst wr_en", 32'(wrEn), 32'h0);
            checkOutput("rst busy", 32'(busy), 32'h0);
            checkOutput("rst ready", 32'(reqReady), 32'h0);
            checkOutput("rst data", dataOut, 32'h0);
            checkOutput("rst timeout", 32'(timeoutPulse), 32'h0);
            checkOutput("rst timeout_id", 32'(timeoutId), 32'h0);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        #3;
        checkOutput("t1 idle grant", 32'(grant), 32'h0);
        nextCycle();
        #3;
        checkOutput("t1 first grant", 32'(grant), 32'h1);
        checkOutput("t1 first data", dataOut, word(0, 0));

        // Tests 2 and 3 as per-cycle vectors.
        addRow(1'b1, 4'b0101, 4'b0000, pack4(word(0,0), '0, word(2,0), '0), 4'b0000, 1'b0, 32'h0, 4'b0000);
        addRow(1'b0, 4'b0101, 4'b0000, pack4(word(0,0), '0, word(2,0), '0), 4'b0001, 1'b1, word(0,0), 4'b0001);
        addRow(1'b0, 4'b0101, 4'b0000, pack4(word(0,1), '0, word(2,0), '0), 4'b0001, 1'b1, word(0,1), 4'b0001);
        addRow(1'b0, 4'b0101, 4'b0001, pack4(word(0,2), '0, word(2,0), '0), 4'b0001, 1'b1, word(0,2), 4'b0001);
        addRow(1'b0, 4'b0100, 4'b0000, pack4('0, '0, word(2,0), '0),        4'b0000, 1'b0, 32'h0, 4'b0000);
        addRow(1'b0, 4'b0100, 4'b0000, pack4('0, '0, word(2,0), '0),        4'b0100, 1'b1, word(2,0), 4'b0100);
        addRow(1'b0, 4'b0100, 4'b0000, pack4('0, '0, word(2,1), '0),        4'b0100, 1'b1, word(2,1), 4'b0100);
        addRow(1'b0, 4'b0100, 4'b0100, pack4('0, '0, word(2,2), '0),        4'b0100, 1'b1, word(2,2), 4'b0100);
        addRow(1'b0, 4'b0000, 4'b0000, '0,                                  4'b0000, 1'b0, 32'h0, 4'b0000);

        allData = pack4(word(0, 7), word(1, 7), word(2, 7), word(3, 7));
        order   = '{0, 1, 2, 3, 0, 1};
        for (int k = 0; k < 12; k++) begin
            if (k % 2 == 0) begin
                addRow(k == 0, 4'b1111, 4'b1111, allData, 4'b0000, 1'b0, 32'h0, 4'b0000);
            end else begin
                addRow(1'b0, 4'b1111, 4'b1111, allData, 4'(1 << order[k/2]), 1'b1,
                       word(order[k/2], 7), 4'(1 << order[k/2]));
            end
        end

        foreach (vecs[i]) applyStimulus(vecs[i], i);

        // Test 4: FIFO full for 5 cycles mid-message on lane 1.
        doReset();
        nextCycle();
        reqValid = 4'b0010;
        reqData  = pack4('0, word(1, 0), '0, '0);
        #3;
        checkOutput("t4 idle grant", 32'(grant), 32'h0);
        nextCycle();
        #3;
        checkOutput("t4 w0 wr_en", 32'(wrEn), 32'h1);
        checkOutput("t4 w0 data", dataOut, word(1, 0));
        for (int i = 0; i < 5; i++) begin
            nextCycle();
            reqData = pack4('0, word(1, 1), '0, '0);
            full    = 1'b1;
            #3;
            checkOutput($sformatf("t4 full%0d wr_en", i), 32'(wrEn), 32'h0);
            checkOutput($sformatf("t4 full%0d ready", i), 32'(reqReady), 32'h0);
            checkOutput($sformatf("t4 full%0d grant", i), 32'(grant), 32'h2);
            checkOutput($sformatf("t4 full%0d timeout", i), 32'(timeoutPulse), 32'h0);
        end
        nextCycle();
        full = 1'b0;
        #3;
        checkOutput("t4 resume wr_en", 32'(wrEn), 32'h1);
        checkOutput("t4 resume data", dataOut, word(1, 1));
        checkOutput("t4 resume ready", 32'(reqReady), 32'h2);
        nextCycle();
        reqData = pack4('0, word(1, 2), '0, '0);
        reqLast = 4'b0010;
        #3;
        checkOutput("t4 last data", dataOut, word(1, 2));
        nextCycle();
        clearInputs();
        #3;
        checkOutput("t4 done busy", 32'(busy), 32'h0);

        // Test 5: lane 1 stalls after two words, lane 3 waiting; watchdog of 16.
        doReset();
        nextCycle();
        reqValid = 4'b1010;
        reqLast  = 4'b1000;
        reqData  = pack4('0, word(1, 0), '0, word(3, 9));
        #3;
        checkOutput("t5 idle grant", 32'(grant), 32'h0);
        nextCycle();
        #3;
        checkOutput("t5 w0 data", dataOut, word(1, 0));
        nextCycle();
        reqData = pack4('0, word(1, 1), '0, word(3, 9));
        #3;
        checkOutput("t5 w1 wr_en", 32'(wrEn), 32'h1);
        for (int i = 0; i < 16; i++) begin
            nextCycle();
            reqValid = 4'b1000;
            #3;
            checkOutput($sformatf("t5 stall%0d timeout", i), 32'(timeoutPulse), 32'h0);
            checkOutput($sformatf("t5 stall%0d grant", i), 32'(grant), 32'h2);
            checkOutput($sformatf("t5 stall%0d wr_en", i), 32'(wrEn), 32'h0);
        end
        nextCycle();
        #3;
        checkOutput("t5 abort timeout", 32'(timeoutPulse), 32'h1);
        checkOutput("t5 abort id", 32'(timeoutId), 32'h1);
        checkOutput("t5 abort grant", 32'(grant), 32'h0);
        nextCycle();
        #3;
        checkOutput("t5 after timeout", 32'(timeoutPulse), 32'h0);
        checkOutput("t5 lane3 grant", 32'(grant), 32'h8);
        checkOutput("t5 lane3 wr_en", 32'(wrEn), 32'h1);
        checkOutput("t5 lane3 data", dataOut, word(3, 9));
        checkOutput("t5 held id", 32'(timeoutId), 32'h1);

        // Test 6: async reset between edges while lane 1 owns the port.
        doReset();
        nextCycle();
        reqValid = 4'b0001;
        reqLast  = 4'b0001;
        reqData  = pack4(word(0, 5), '0, '0, '0);
        nextCycle();
        #3;
        checkOutput("t6 lane0 wr_en", 32'(wrEn), 32'h1);
        nextCycle();
        reqValid = 4'b0010;
        reqLast  = 4'b0000;
        reqData  = pack4('0, word(1, 5), '0, '0);
        #3;
        checkOutput("t6 idle grant", 32'(grant), 32'h0);
        nextCycle();
        #3;
        checkOutput("t6 lane1 grant", 32'(grant), 32'h2);
        checkOutput("t6 lane1 wr_en", 32'(wrEn), 32'h1);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("t6 async wr_en", 32'(wrEn), 32'h0);
        checkOutput("t6 async grant", 32'(grant), 32'h0);
        checkOutput("t6 async busy", 32'(busy), 32'h0);
        @(posedge clk);
        #1;
        rst      = 1'b1;
        reqValid = 4'b0011;
        reqLast  = 4'b0001;
        reqData  = pack4(word(0, 6), word(1, 5), '0, '0);
        #3;
        checkOutput("t6 post-rst idle", 32'(grant), 32'h0);
        nextCycle();
        #3;
        checkOutput("t6 restart grant", 32'(grant), 32'h1);
        checkOutput("t6 restart data", dataOut, word(0, 6));

        clearInputs();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fix_fifo_wr_arbiter.md
Name: fix_fifo_wr_arbiter

Overview:
- Shares the single write port of the message FIFO between NUM_REQ FIX message producers (parser/session lanes).
- Grants are per message: the owner keeps the port until it delivers its last word, so messages never interleave.
- Arbitration is round-robin, honours FIFO full backpressure, and has a stall watchdog that reclaims the port from a dead producer.
- Sits between the parser lanes and the FIFO write side (wr_cs/wr_en/data).

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- DATA_WIDTH, 32: word width, equal to FIFO DATA_WIDTH.
- TIMEOUT_CYCLES, 64: consecutive owner-idle cycles before the grant is revoked (>=2).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid_i  in  NUM_REQ  per-lane word valid.
- req_data_i  in  NUM_REQ*DATA_WIDTH  per-lane word; lane i at [i*DATA_WIDTH +: DATA_WIDTH].
- req_last_i  in  NUM_REQ  per-lane last word of message.
- req_ready_o  out  NUM_REQ  per-lane word accepted when valid&ready.
- full_i  in  1  FIFO full_o.
- wr_cs_o  out  1  FIFO write chip select.
- wr_en_o  out  1  FIFO write enable.
- data_o  out  DATA_WIDTH  FIFO write data.
- grant_o  out  NUM_REQ  one-hot current owner, 0 when idle.
- busy_o  out  1  a message is in progress.
- timeout_o  out  1  one-cycle pulse on watchdog abort.
- timeout_id_o  out  $clog2(NUM_REQ)  aborted lane, held until next abort.

Behaviour:
- Reset (rst=0, async): state=IDLE, owner=0, rr_last=NUM_REQ-1, idle_cnt=0, timeout_id_o=0. All outputs are 0 immediately, since combinational outputs derive from the reset state.
- FSM IDLE:
  - If any req_valid_i, pick the first set bit scanning from (rr_last+1) mod NUM_REQ upward with wrap.
  - Register owner and go to XFER.
  - No ready and no write in IDLE, giving a 1-cycle arbitration bubble per message.
- FSM XFER:
  - grant_o=onehot(owner), busy_o=1.
  - req_ready_o[owner] = !full_i; all other lanes' ready = 0.
  - wr_en_o = wr_cs_o = req_valid_i[owner] & !full_i (combinational, zero latency).
  - data_o = owner lane data, driven in XFER regardless of valid; 0 in IDLE.
  - On accept with req_last_i[owner]=1: rr_last<=owner, go to IDLE.
  - A 1-word message occupies exactly one XFER cycle.
- Watchdog (XFER only):
  - idle_cnt increments when req_valid_i[owner]=0 and full_i=0.
  - idle_cnt clears on any accept. It holds, not increments, while full_i=1; FIFO stalls never time out.
  - When idle_cnt reaches TIMEOUT_CYCLES-1 and increments: pulse timeout_o, timeout_id_o<=owner, rr_last<=owner, go to IDLE, clear idle_cnt.
  - No word is written in the abort cycle. The remainder of an aborted message, if it arrives later, is treated as a new message.
- full_i asserted mid-message: no write and ready=0, data held by the producer, owner unchanged. Writing resumes the cycle full_i falls.
- Simultaneous requests: only the rr order decides. A lane that just finished is lowest priority next round.
- Reset mid-message: abort at once. The partial message already in the FIFO is the consumer's concern.
- Width rule: idle_cnt is $clog2(TIMEOUT_CYCLES+1) bits and saturates, never wraps.

Decomposition:
- Package fix_fifo_arb_pkg holds:
  - state enum {IDLE, XFER};
  - function rr_pick(req, last) returning index and found flag;
  - localparam IDX_W = $clog2(NUM_REQ).
- One sub-module is natural: rr_picker (combinational rotate-priority-encode), reusable by the read-side scheduler.

Test Plan:
1. Hold rst=0 with lanes valid -> all outputs 0, no wr_en_o. Release -> grant_o=0001 one cycle after the first valid.
2. Lanes 0 and 2 valid at once, 3-word messages (A0..A2, C0..C2) -> grant_o=0001, wr_en_o high 3 consecutive cycles with A0..A2, 1 bubble, then grant_o=0100 and C0..C2.
3. All 4 lanes continuously sending 1-word messages -> grant order 0,1,2,3,0,1; exactly one write every 2 cycles.
4. Lane 1 mid-message, full_i high 5 cycles -> wr_en_o=0 and req_ready_o=0 for 5 cycles, no timeout_o, next word written the cycle full_i falls.
5. TIMEOUT_CYCLES=16, lane 1 sends 2 words without last then drops valid, lane 3 waiting -> timeout_o pulses 16 cycles after the last accept, timeout_id_o=1, IDLE for 1 cycle, then grant_o=1000.
6. Async rst pulse between clock edges during XFER -> wr_en_o, grant_o and busy_o drop before the next edge. After release the arbiter restarts from lane 0 priority.
